// File: rtl/axi_pkg.sv
// Shared AXI constants, channel widths and FSM state types for the slave memory.
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// DEPTH x 32 word store: byte-enabled synchronous write, asynchronous read.
// Zero latency on the read port; no flow control, the caller gates the write enable.
module axi_slave_mem_ram
  import axi_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter bit INIT_ZERO = 1'b1,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  if (INIT_ZERO) begin : g_clear
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
        for (int b = 0; b < STRB_W; b++)
          if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end else begin : g_keep
    // Contents survive reset; writes are still blocked while reset is held.
    always_ff @(posedge clk) begin
      if (we && !rst) begin
        for (int b = 0; b < STRB_W; b++)
          if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI INCR-burst slave memory with independent write (AW/W/B) and read (AR/R) FSMs.
// Read data follows AR by one cycle; rvalid/bvalid hold with stable payload until rready/bready.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  w_state_t          w_state, w_state_nxt;
  logic [IDX_W-1:0]  w_idx, w_idx_nxt;
  logic [LEN_W:0]    w_cnt, w_cnt_nxt;
  logic              w_err, w_err_nxt;
  logic              mem_we;

  r_state_t          r_state, r_state_nxt;
  logic [IDX_W-1:0]  r_idx, r_idx_nxt;
  logic [LEN_W:0]    r_cnt, r_cnt_nxt;
  logic              r_err, r_err_nxt;
  logic [DATA_W-1:0] ram_rdata;

  logic aw_err, ar_err;
  assign aw_err = {1'b0, awaddr} >= LIMIT;
  assign ar_err = {1'b0, araddr} >= LIMIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      w_idx   <= w_idx_nxt;
      w_cnt   <= w_cnt_nxt;
      w_err   <= w_err_nxt;
      r_state <= r_state_nxt;
      r_idx   <= r_idx_nxt;
      r_cnt   <= r_cnt_nxt;
      r_err   <= r_err_nxt;
    end
  end

  // Write path: w_cnt holds the beats still owed, so the last beat sees w_cnt == 1.
  always_comb begin
    w_state_nxt = w_state;
    w_idx_nxt   = w_idx;
    w_cnt_nxt   = w_cnt;
    w_err_nxt   = w_err;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    bresp       = RESP_OKAY;
    mem_we      = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          w_idx_nxt   = awaddr[2 +: IDX_W];
          w_cnt_nxt   = (LEN_W+1)'(awlen) + 1'b1;
          w_err_nxt   = aw_err;
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we    = !w_err;
          w_idx_nxt = w_idx + 1'b1;
          w_cnt_nxt = w_cnt - 1'b1;
          if (w_cnt == (LEN_W+1)'(1)) w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read path: rdata comes straight off the async port, so a same-cycle write is not yet visible.
  always_comb begin
    r_state_nxt = r_state;
    r_idx_nxt   = r_idx;
    r_cnt_nxt   = r_cnt;
    r_err_nxt   = r_err;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rdata       = '0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          r_idx_nxt   = araddr[2 +: IDX_W];
          r_cnt_nxt   = (LEN_W+1)'(arlen) + 1'b1;
          r_err_nxt   = ar_err;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rdata  = r_err ? '0 : ram_rdata;
        if (rready) begin
          r_idx_nxt = r_idx + 1'b1;
          r_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == (LEN_W+1)'(1)) r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  axi_slave_mem_ram #(
    .DEPTH    (DEPTH),
    .INIT_ZERO(INIT_ZERO)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(w_idx),
    .wstrb(wstrb),
    .wdata(wdata),
    .raddr(r_idx),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter DEPTH, default 256, memory size in 32-bit words (power of two).
REQ-002 Parameter INIT_ZERO, default 1, when 1 the memory clears to zero on reset.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 awaddr/awlen/awvalid  input  32/8/1  write address channel; awready output 1.
REQ-006 wdata/wstrb/wvalid  input  32/4/1  write data channel; wready output 1.
REQ-007 bresp output 2, bvalid output 1, bready input 1  write response channel.
REQ-008 araddr/arlen/arvalid  input  32/8/1  read address channel; arready output 1.
REQ-009 rdata output 32, rvalid output 1, rready input 1  read data channel (no rlast/rresp; the master counts beats).

Function
REQ-010 Write and read paths SHALL be independent FSMs; both may run concurrently.
REQ-011 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-012 On awvalid&&awready: latch word index awaddr[2+:log2(DEPTH)], beat count awlen+1, and the error flag (awaddr >= DEPTH*4); go to W_DATA next cycle.
REQ-013 Each wvalid&&wready beat SHALL write byte lanes where wstrb[i]=1 at the current index, then increment the index modulo DEPTH (INCR burst, wrap at DEPTH).
REQ-014 When the error flag is set, beats SHALL be accepted but not written.
REQ-015 After beat awlen+1 is accepted, go to W_RESP; bresp=2'b00 (OKAY), or 2'b10 (SLVERR) if the error flag is set.
REQ-016 bvalid and bresp SHALL hold until bready; on bvalid&&bready return to W_IDLE (awready high the next cycle).
REQ-017 Read FSM states SHALL be R_IDLE, R_DATA; arready=1 only in R_IDLE, rvalid=1 only in R_DATA.
REQ-018 On arvalid&&arready: latch the index, the beat count arlen+1, and the error flag (araddr >= DEPTH*4); rvalid SHALL rise the next cycle (1-cycle latency).
REQ-019 rdata SHALL equal mem[index], or 32'h0 if the error flag is set, and hold stable while rvalid&&!rready.
REQ-020 On rvalid&&rready: increment the index modulo DEPTH and decrement the count; the final beat returns to R_IDLE with rvalid=0 the next cycle.
REQ-021 Same-word collision: a read beat completing in the same cycle as a write beat to that word SHALL return the pre-write data.
REQ-022 awlen=0/arlen=0 SHALL give single-beat bursts; awlen=255 gives 256 beats, which wrap fully when DEPTH=256.

Reset
REQ-023 With rst high: both FSMs SHALL be idle; awready=1, arready=1, wready=0, bvalid=0, rvalid=0, bresp=2'b00, rdata=32'h0.
REQ-024 Assertion mid-burst SHALL abort the burst immediately, with no further memory writes and no response issued.
REQ-025 Memory contents SHALL clear to zero on reset when INIT_ZERO=1 and be retained otherwise.

Structure
REQ-026 The shared package axi_pkg SHALL hold the resp constants (OKAY=2'b00, SLVERR=2'b10), the write/read state enums, and the address/data/len widths.
REQ-027 Storage SHALL be the sub-module axi_slave_mem_ram: one byte-enabled write port and one asynchronous read port, DEPTH x 32.
REQ-028 Target size: 150-300 lines of RTL total.

Verification
REQ-029 Single write: awaddr=0x10, awlen=0, wdata=0xA5A5_1234, wstrb=4'hF, then read araddr=0x10, arlen=0 -> bresp=00, rdata=0xA5A5_1234.
REQ-030 Burst with strobes: awaddr=0x0, awlen=3, data 1..4, wstrb=4'b0011 on beat 2 over a prefilled 0xFFFF_FFFF word -> beat 2 word reads 0xFFFF_0002; read burst arlen=3 returns 4 beats in order.
REQ-031 Backpressure: rready toggled 1-0-0-1 during a 4-beat read, and bready held low 5 cycles -> rdata and bvalid/bresp stable while stalled, no beat lost or duplicated.
REQ-032 Error and wrap: awaddr=DEPTH*4 -> bresp=10 with memory unchanged; read of araddr=(DEPTH-1)*4 with arlen=1 -> second beat returns mem[0].
REQ-033 Concurrency and reset: simultaneous write and read bursts complete independently; rst asserted mid write burst -> awready=1, bvalid=0, and later beats are not written.
